// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into rise/fall/short/long/repeat event pulses
module button_event_gen #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int REPEAT_EN     = 1,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic reset_n,
    input  logic debounced,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);
    typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;
    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES);
    localparam logic REP_ON = (REPEAT_EN != 0);
    state_t state;
    logic d_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = cnt + CNT_W'(1);
    // press FSM with registered one-cycle event pulses; a low sample always beats a terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            d_q          <= 1'b0;
            cnt          <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            d_q          <= debounced;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (debounced && !d_q) begin
                        state      <= PRESS;
                        rise_pulse <= 1'b1;
                        cnt        <= CNT_W'(1);
                        held       <= 1'b1;
                    end
                end
                PRESS: begin
                    if (!debounced) begin
                        state       <= IDLE;
                        fall_pulse  <= 1'b1;
                        short_press <= 1'b1;
                        cnt         <= '0;
                        held        <= 1'b0;
                    end else if (cnt_inc == LONG_T) begin
                        state      <= LONG;
                        long_press <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LONG: begin
                    if (!debounced) begin
                        state      <= IDLE;
                        fall_pulse <= 1'b1;
                        cnt        <= '0;
                        held       <= 1'b0;
                    end else if (cnt_inc == REP_T) begin
                        repeat_pulse <= REP_ON;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: run-length reference model plus directed press scenarios
module tb_button_event_gen;
    localparam int L = 8;
    localparam int R = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic debounced = 1'b0;
    logic r1, f1, s1, l1, p1, h1;
    logic r2, f2, s2, l2, p2, h2;
    int checks = 0;
    int fails = 0;
    int n_rise, n_fall, n_short, n_long, n_rep, n_rep2, n_held, n_any;
    // reference state: previous sample and length of the current high run
    logic prev;
    int run;
    logic [5:0] exp_v;

    always #5 clk = ~clk;

    button_event_gen #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .debounced(debounced),
        .rise_pulse(r1), .fall_pulse(f1), .short_press(s1),
        .long_press(l1), .repeat_pulse(p1), .held(h1)
    );

    button_event_gen #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(0), .CNT_W(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .debounced(debounced),
        .rise_pulse(r2), .fall_pulse(f2), .short_press(s2),
        .long_press(l2), .repeat_pulse(p2), .held(h2)
    );

    // outputs derived from the run length: long at run==L, repeat every R samples beyond L
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev  <= 1'b0;
            run   <= 0;
            exp_v <= '0;
        end else begin
            automatic int nrun = debounced ? run + 1 : 0;
            exp_v <= {debounced && !prev,
                      !debounced && prev,
                      !debounced && prev && (run < L),
                      debounced && (nrun == L),
                      debounced && (nrun > L) && ((nrun - L) % R == 0),
                      debounced};
            prev <= debounced;
            run  <= nrun;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic clr();
        n_rise = 0; n_fall = 0; n_short = 0; n_long = 0;
        n_rep = 0; n_rep2 = 0; n_held = 0; n_any = 0;
    endtask

    // one clock: drive inputs after the edge, then check both DUTs against the model at the falling edge
    task automatic cyc(input logic v, input logic rn = 1'b1);
        @(posedge clk);
        #2;
        debounced = v;
        reset_n = rn;
        @(negedge clk);
        chk("dut1 {rise,fall,short,long,rep,held}", int'({r1, f1, s1, l1, p1, h1}), int'(exp_v));
        chk("dut2 {rise,fall,short,long,rep,held}", int'({r2, f2, s2, l2, p2, h2}), int'(exp_v & 6'b111101));
        n_rise  += int'(r1);
        n_fall  += int'(f1);
        n_short += int'(s1);
        n_long  += int'(l1);
        n_rep   += int'(p1);
        n_rep2  += int'(p2);
        n_held  += int'(h1);
        n_any   += int'(r1 | f1 | s1 | l1 | p1 | h1);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0);
    endtask

    initial begin
        clr();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        chk("reset outputs", n_any, 0);
        clr();
        for (int i = 0; i < 100; i++) cyc(1'b0);
        chk("idle activity", n_any, 0);

        clr();
        hold(L - 1);
        chk("short: rise", n_rise, 1);
        chk("short: fall", n_fall, 1);
        chk("short: short", n_short, 1);
        chk("short: long", n_long, 0);
        chk("short: held cycles", n_held, L - 1);

        clr();
        hold(L);
        chk("exact L: long", n_long, 1);
        chk("exact L: short", n_short, 0);

        clr();
        hold(20);
        chk("long: long", n_long, 1);
        chk("long: repeats", n_rep, 3);
        chk("long: short", n_short, 0);
        chk("long: fall", n_fall, 1);
        chk("no-repeat dut: repeats", n_rep2, 0);

        clr();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        cyc(1'b0);
        chk("burst: rise", n_rise, 6);
        chk("burst: fall", n_fall, 6);
        chk("burst: short", n_short, 6);

        clr();
        for (int i = 0; i < 4; i++) cyc(1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("reset abort: fall", n_fall, 0);
        clr();
        hold(L + 2);
        chk("after reset: rise", n_rise, 1);
        chk("after reset: long", n_long, 1);
        chk("after reset: short", n_short, 0);
        chk("after reset: fall", n_fall, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Downstream consumer of the debouncer's `debounced` level.
- Converts the clean level into single-cycle event pulses:
  - rising edge
  - falling edge
  - short press (released before the long threshold)
  - long press (threshold reached while held)
  - auto-repeat ticks while held after a long press
- Feeds UI/menu logic, which must only ever see one-cycle, mutually consistent events per physical press.

Parameters:
- LONG_CYCLES, default 50000000: number of consecutive high samples of `debounced` that qualifies a long press; must be >= 2.
- REPEAT_CYCLES, default 10000000: period in clk cycles of `repeat_pulse` after a long press; must be >= 1.
- REPEAT_EN, default 1: 1 enables auto-repeat; 0 suppresses `repeat_pulse` entirely.
- CNT_W, default 26: hold-counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- debounced  input  1  clean button level from the debouncer, synchronous to clk.
- rise_pulse  output  1  one-cycle pulse on a 0->1 transition of `debounced`.
- fall_pulse  output  1  one-cycle pulse on a 1->0 transition of `debounced`.
- short_press  output  1  one-cycle pulse on release when the hold was shorter than LONG_CYCLES samples.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES samples.
- repeat_pulse  output  1  periodic one-cycle pulse while held in the long state.
- held  output  1  level; high while the FSM is in PRESS or LONG.

Behaviour:
- **Registered input.** `d_q` is the registered previous sample of `debounced`.
  - rise detected at edge k when `debounced`=1 and `d_q`=0.
  - fall detected at edge k when `debounced`=0 and `d_q`=1.
- **Registered outputs.** All outputs are registered. A pulse caused by the sample at edge k is high for exactly the cycle following edge k (latency 1), then low.
- **Reset (async, reset_n=0).**
  - state=IDLE, `d_q`=0, counter=0.
  - All outputs 0 immediately.
  - If `debounced` is already high at reset release, the first edge sees a rise and enters PRESS.
  - Asserting reset mid-press aborts the press: no fall, short or long pulse is generated for it.
- **Counter semantics.** The counter holds the number of consecutive high samples (rise sample = 1).
- **FSM (3 states):**
  - IDLE:
    - rise -> PRESS; `rise_pulse`=1; counter=1.
    - otherwise stay.
  - PRESS:
    - `debounced`=0 -> IDLE; `fall_pulse`=1; `short_press`=1.
    - `debounced`=1 and counter+1==LONG_CYCLES -> LONG; `long_press`=1; counter=0.
    - else counter += 1.
  - LONG:
    - `debounced`=0 -> IDLE; `fall_pulse`=1; no `short_press`.
    - `debounced`=1: counter += 1. When counter reaches REPEAT_CYCLES: `repeat_pulse`=REPEAT_EN and counter=0.
  - Unused encodings -> IDLE.
- **held** = 1 in PRESS or LONG, registered alongside the state.
- **Simultaneous events.** A fall sample always wins over a terminal count in the same cycle. The low sample is not counted, so a hold of LONG_CYCLES-1 samples yields `short_press` only.
- **Exclusivity.**
  - Per press: exactly one `rise_pulse`, at most one `fall_pulse`.
  - Exactly one of `short_press`/`long_press` per completed press.
  - `short_press` and `fall_pulse` coincide; no other two pulses are ever high in the same cycle.
- **Minimum press.** A one-sample press gives `rise_pulse` in one cycle and `fall_pulse`+`short_press` in the next. No overlap, no missed events.
- **Wrap-around.** The counter never wraps: it is cleared at every terminal count and on every state change.
- **Width.** Comparisons use CNT_W-bit unsigned arithmetic; parameters are truncated to CNT_W bits (the CNT_W constraint above prevents loss).

Test Plan:
- Reset with `debounced`=0, release, idle for 100 cycles -> all outputs stay 0, `held`=0.
- LONG_CYCLES=8, REPEAT_CYCLES=4: hold `debounced` high for 7 samples -> `rise_pulse` at cycle 1; `fall_pulse`+`short_press` together one cycle after the first low sample; no `long_press`; `held` high 7 cycles.
- Same parameters, hold 20 samples -> `long_press` after sample 8; `repeat_pulse` after samples 12, 16, 20; on release `fall_pulse` only; `short_press` never asserted.
- REPEAT_EN=0, hold 20 samples -> `long_press` once, zero `repeat_pulse`, `fall_pulse` on release.
- Single-sample press, then five back-to-back 1-high/1-low presses -> exactly 6 `rise_pulse`, 6 `fall_pulse`, 6 `short_press`; no two pulses overlap except `fall`+`short`.
- Assert reset_n low during sample 5 of a hold, release with `debounced` still high -> outputs 0 during reset; fresh `rise_pulse` one cycle after release; `long_press` after 8 further samples.
